// File: rtl/gen_ppbuff_ctrl_pkg.sv
// Shared types for the ping-pong buffer slot sequencer.
// The optional stall statistic is enabled with GEN_PPBUFF_CTRL_STATS_EN.
package gen_ppbuff_ctrl_pkg;

    localparam int DP_DEFAULT = 8;
    localparam int STALL_W    = 32;

    typedef logic [STALL_W-1:0] stall_t;

    localparam stall_t STALL_MAX = '1;

endpackage

// File: rtl/gen_ppbuff_ctrl_if.sv
// Producer/consumer handshake and buffer-control bundle of the slot sequencer.
// The master side is the controller; the slave side is the surrounding datapath.
interface gen_ppbuff_ctrl_if
    import gen_ppbuff_ctrl_pkg::*;
#(
    parameter int DP = DP_DEFAULT
);
    localparam int AW = $clog2(DP);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_index;
    logic          buf_push;
    logic          buf_pop;
    logic [AW-1:0] buf_index;
    logic          buf_flush;

    modport master (
        input  flush, in_valid, out_ready,
        output in_ready, out_valid, out_index,
        output buf_push, buf_pop, buf_index, buf_flush
    );

    modport slave (
        output flush, in_valid, out_ready,
        input  in_ready, out_valid, out_index,
        input  buf_push, buf_pop, buf_index, buf_flush
    );

endinterface

// File: rtl/gen_dffren.sv
// Enabled D flip-flop group with asynchronous active-low clear.
module gen_dffren #(
    parameter int DW = 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          en,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Hold the stored value unless enabled; clear asynchronously on reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            qout <= '0;
        end else if (en) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/gen_ppbuff_ctrl.sv
// In-order slot sequencer for an index-addressed ping-pong buffer.
// Allocates write slots for producer pushes, presents the oldest occupied
// slot to the consumer and tracks per-slot occupancy.
// Optional: define GEN_PPBUFF_CTRL_STATS_EN to build the saturating full-stall counter.
module gen_ppbuff_ctrl
    import gen_ppbuff_ctrl_pkg::*;
#(
    parameter int DP = DP_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    gen_ppbuff_ctrl_if.master      bus,
    output logic [DP-1:0]          slot_valid,
    output logic                   empty,
    output logic                   full,
    output logic [STALL_W-1:0]     stall_cnt
);

    localparam int AW = $clog2(DP);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DP);

    logic [AW-1:0] wr_ptr, wr_nxt;
    logic [AW-1:0] rd_ptr, rd_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic [DP-1:0] occ, occ_nxt;
    logic          acc, iss;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_FULL);

    // Accept side: never depends on out_ready, so a full buffer never takes a push.
    assign bus.in_ready  = ~full & ~bus.flush;
    assign acc           = bus.in_valid & bus.in_ready;
    assign bus.buf_push  = acc;
    assign bus.buf_index = wr_ptr;

    // Issue side: the oldest slot is offered unless a flush is discarding it.
    assign bus.out_valid = ~empty & ~bus.flush;
    assign bus.out_index = rd_ptr;
    assign iss           = bus.out_valid & bus.out_ready;
    assign bus.buf_pop   = iss;

    assign bus.buf_flush = bus.flush;
    assign slot_valid    = occ;

    // Next-state of pointers, count and occupancy; flush clears everything.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_nxt  = wr_ptr + AW'(1);
        rd_nxt  = rd_ptr + AW'(1);
        cnt_nxt = cnt;
        occ_nxt = occ;
        if (bus.flush) begin
            wr_nxt  = '0;
            rd_nxt  = '0;
            cnt_nxt = '0;
            occ_nxt = '0;
        end else begin
            case ({acc, iss})
                2'b10:   cnt_nxt = cnt + (AW+1)'(1);
                2'b01:   cnt_nxt = cnt - (AW+1)'(1);
                default: cnt_nxt = cnt;
            endcase
            // acc and iss on the same slot would need cnt == 0, where iss is impossible.
            if (acc) occ_nxt[wr_ptr] = 1'b1;
            if (iss) occ_nxt[rd_ptr] = 1'b0;
        end
    end

    gen_dffren #(.DW(AW)) u_wr_ptr (
        .CLK(CLK), .RSTn(RSTn), .en(acc | bus.flush), .dnxt(wr_nxt), .qout(wr_ptr)
    );

    gen_dffren #(.DW(AW)) u_rd_ptr (
        .CLK(CLK), .RSTn(RSTn), .en(iss | bus.flush), .dnxt(rd_nxt), .qout(rd_ptr)
    );

    gen_dffren #(.DW(AW+1)) u_cnt (
        .CLK(CLK), .RSTn(RSTn), .en(acc | iss | bus.flush), .dnxt(cnt_nxt), .qout(cnt)
    );

    gen_dffren #(.DW(DP)) u_occ (
        .CLK(CLK), .RSTn(RSTn), .en(acc | iss | bus.flush), .dnxt(occ_nxt), .qout(occ)
    );

`ifdef GEN_PPBUFF_CTRL_STATS_EN
    stall_t stall_q;

    // Count cycles where the producer is held off by a full buffer; saturate, survive flush.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_q <= '0;
        end else if (bus.in_valid & full & ~bus.flush & (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + stall_t'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gen_ppbuff_ctrl.sv
// Self-checking bench for gen_ppbuff_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based model of the slot order.
module tb_gen_ppbuff_ctrl;
    import gen_ppbuff_ctrl_pkg::*;

    localparam int DP = 8;
    localparam int AW = $clog2(DP);

    logic              CLK  = 1'b0;
    logic              RSTn = 1'b0;
    logic [DP-1:0]     slot_valid;
    logic              empty;
    logic              full;
    logic [STALL_W-1:0] stall_cnt;

    gen_ppbuff_ctrl_if #(.DP(DP)) bus ();

    gen_ppbuff_ctrl #(.DP(DP)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .bus        (bus),
        .slot_valid (slot_valid),
        .empty      (empty),
        .full       (full),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Model: queue of occupied slot indices in arrival order, next free slot, stall count.
    int unsigned     q[$];
    int unsigned     wpos;
    longint unsigned stall_m;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wpos    = 0;
        stall_m = 0;
    endtask

    // Compare every output against what the model says for the current inputs.
    task automatic check_outputs();
        int unsigned   n;
        logic          e_full, e_in_ready, e_out_valid;
        logic [DP-1:0] mask;
        n           = q.size();
        e_full      = (n == DP);
        e_in_ready  = !e_full && !bus.flush;
        e_out_valid = (n != 0) && !bus.flush;
        mask        = '0;
        foreach (q[i]) mask[q[i]] = 1'b1;
        check("in_ready",   32'(bus.in_ready),  32'(e_in_ready));
        check("out_valid",  32'(bus.out_valid), 32'(e_out_valid));
        check("out_index",  32'(bus.out_index), (n != 0) ? q[0] : wpos);
        check("buf_push",   32'(bus.buf_push),  32'(bus.in_valid && e_in_ready));
        check("buf_pop",    32'(bus.buf_pop),   32'(e_out_valid && bus.out_ready));
        check("buf_index",  32'(bus.buf_index), wpos);
        check("buf_flush",  32'(bus.buf_flush), 32'(bus.flush));
        check("slot_valid", 32'(slot_valid),    32'(mask));
        check("empty",      32'(empty),         32'(n == 0));
        check("full",       32'(full),          32'(e_full));
        check("stall_cnt",  stall_cnt,          32'(stall_m));
    endtask

    // Apply one cycle of inputs: check before the edge, then advance the model.
    task automatic step(input logic iv, input logic ordy, input logic fl);
        logic acc_m, iss_m;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        check_outputs();
        acc_m = iv && (q.size() != DP) && !fl;
        iss_m = ordy && (q.size() != 0) && !fl;
`ifdef GEN_PPBUFF_CTRL_STATS_EN
        if (iv && (q.size() == DP) && !fl && stall_m != 64'hFFFF_FFFF) stall_m++;
`endif
        @(posedge CLK);
        if (fl) begin
            q.delete();
            wpos = 0;
        end else begin
            if (iss_m) void'(q.pop_front());
            if (acc_m) begin
                q.push_back(wpos);
                wpos = (wpos + 1) % DP;
            end
        end
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        model_reset();

        // Reset state.
        #12;
        check_outputs();
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Fill: slots 0..7 allocated in order, then full.
        for (int i = 0; i < DP; i++) step(1'b1, 1'b0, 1'b0);
        check("fill_full",       32'(full),       32'd1);
        check("fill_slot_valid", 32'(slot_valid), 32'hFF);
        step(1'b0, 1'b0, 1'b0);

        // Drain: out_index 0..7 in order.
        for (int i = 0; i < DP; i++) step(1'b0, 1'b1, 1'b0);
        check("drain_empty",      32'(empty),      32'd1);
        check("drain_slot_valid", 32'(slot_valid), 32'h00);

        // Steady stream from one held entry; pointers wrap several times.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
        check("stream_slot_count", 32'($countones(slot_valid)), 32'd1);

        // Build up to five entries, then flush against a concurrent push and pop.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        check("pre_flush_count", 32'($countones(slot_valid)), 32'd5);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("post_flush_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream, asserted between edges.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Hold a full buffer against a waiting producer for ten cycles.
        for (int i = 0; i < DP; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
`ifdef GEN_PPBUFF_CTRL_STATS_EN
        check("stall_after_10", stall_cnt, 32'd10);
`else
        check("stall_after_10", stall_cnt, 32'd0);
`endif
        // A flush must not clear the stall statistic.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        end
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gen_ppbuff_ctrl.md
Name: gen_ppbuff_ctrl

Overview:
- In-order slot sequencer for an index-addressed ping-pong buffer: DP slots, DW-wide, with per-slot push/pop/flush and a write-slot index input.
- Allocates the write slot for each upstream push and presents the oldest occupied slot to the downstream consumer.
- Tracks per-slot occupancy and drives the buffer's push/pop/index/flush controls.
- Sits between a producer stage (valid/ready) and a consumer stage (valid/ready) that reads the buffer's flattened data bus by slot index.

Parameters:
- DP, 8, number of buffer slots; power of two, ≥2.
- AW, $clog2(DP), slot index width; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- flush  in  1  discard all slots; highest priority
- in_valid  in  1  producer has an entry
- in_ready  out  1  controller accepts an entry this cycle
- out_valid  out  1  oldest slot is available to the consumer
- out_ready  in  1  consumer takes the slot this cycle
- out_index  out  AW  slot index of the oldest entry (read mux select)
- buf_push  out  1  push strobe to buffer
- buf_pop  out  1  pop strobe to buffer
- buf_index  out  AW  write slot index to buffer
- buf_flush  out  1  flush strobe to buffer
- slot_valid  out  DP  per-slot occupancy bitmap
- empty  out  1  cnt == 0
- full  out  1  cnt == DP
- stall_cnt  out  32  full-stall counter (optional feature)

Behaviour:
- Clock and reset: one clock, CLK; reset RSTn is asynchronous and active-low.
- State registers: wr_ptr[AW-1:0], rd_ptr[AW-1:0], cnt[AW:0], occ[DP-1:0].
  - On RSTn=0 all clear to 0, immediately (asynchronous).
- Reset output values: in_ready=1, out_valid=0, buf_push=0, buf_pop=0, buf_index=0, out_index=0, buf_flush=0, slot_valid=0, empty=1, full=0, stall_cnt=0.
- Accept path:
  - in_ready = ~full & ~flush. It has no combinational dependence on out_ready, so there is no push into a full buffer even when a pop is simultaneous.
  - acc = in_valid & in_ready.
  - buf_push = acc and buf_index = wr_ptr, both combinational; data is captured at the same edge.
- Issue path:
  - out_valid = ~empty & ~flush; out_index = rd_ptr.
  - iss = out_valid & out_ready; buf_pop = iss.
- Edge update, no flush:
  - wr_ptr += acc; rd_ptr += iss. Pointers wrap from DP-1 to 0 by natural modulo-2^AW overflow.
  - cnt += acc - iss; simultaneous acc and iss leave cnt unchanged.
  - occ[wr_ptr] set on acc; occ[rd_ptr] cleared on iss.
  - When rd_ptr == wr_ptr, acc and iss together are only possible if cnt == 0. Since out_valid is 0 at cnt == 0, this cannot occur.
- Flush:
  - buf_flush = flush, combinational.
  - buf_push and buf_pop are forced to 0 in the flush cycle.
  - At the next edge wr_ptr, rd_ptr, cnt and occ are all cleared.
  - Flush overrides any concurrent in_valid or out_ready.
- Latency:
  - An entry accepted at edge N is visible with out_valid=1 from cycle N+1.
  - Throughput is 1 push plus 1 pop per cycle.
- slot_valid = occ, registered. empty and full are decoded from cnt.
- Invariant, for verification: popcount(occ) == cnt at all times.

Optional Feature:
- Macro: GEN_PPBUFF_CTRL_STATS_EN.
- Defined:
  - 32-bit stall_cnt increments each cycle in which in_valid & full & ~flush.
  - It saturates at 0xFFFFFFFF.
  - It is cleared only by reset; flush does not clear it.
- Undefined: stall_cnt is tied to 0 and no counter register is built.

Decomposition:
- Shared package: none needed. AW is derived locally from DP.
- State registers are built from the existing gen_dffren (dnxt/qout/en, CLK/RSTn) instances, one per register group, with enables:
  - wr_ptr: acc|flush
  - rd_ptr: iss|flush
  - cnt: acc|iss|flush
  - occ: acc|iss|flush
- No new sub-module is required.

Test Plan:
- Reset, then 8 back-to-back in_valid with out_ready=0 → buf_index 0..7, full=1 after the 8th edge, in_ready=0, slot_valid=0xFF.
- From full, out_ready=1 for 8 cycles → out_index 0..7 in order, buf_pop each cycle, empty=1 at the end, slot_valid=0x00.
- Steady stream with in_valid=out_ready=1 for 20 cycles starting from cnt=1 → cnt stays 1, pointers wrap 7→0, buf_push and buf_pop asserted every cycle.
- cnt=5 with flush=1 alongside in_valid=1, out_ready=1 → buf_push=0, buf_pop=0, buf_flush=1; next cycle cnt=0, wr_ptr=rd_ptr=0, empty=1.
- Assert RSTn=0 mid-stream between clock edges → all outputs at reset values immediately, without waiting for a clock edge.
- With GEN_PPBUFF_CTRL_STATS_EN, hold full and in_valid=1 for 10 cycles → stall_cnt=10. Without the macro, stall_cnt=0.
